muldiv_seq_cop: RTL

Parametrised iterative multiply/divide coprocessor, the successor to the fixed 16-bit, vendor-IP-based multiply/divide unit in the execute stage.
- Self-contained shift-add multiplier and restoring divider, DATA_W-generic.
- Signed and unsigned modes.
- Valid/ready handshake on both sides, replacing the fixed cycle-count polling.
- Divide-by-zero flag qualified with the result.

---
 rtl/muldiv_seq_cop_if.sv | 26 ++
 rtl/muldiv_seq_cop.sv | 106 ++++++++++
 2 files changed

// File: rtl/muldiv_seq_cop_if.sv
// Request/response bundle for the iterative multiply/divide coprocessor.
// Requester drives operands and out_ready; the unit drives status and result.
interface muldiv_seq_cop_if #(
  parameter int DATA_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [DATA_W-1:0]     rs;
  logic [DATA_W-1:0]     rt;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   result;
  logic                  div_by_zero;
  logic                  busy;

  modport master (
    output in_valid, mode, rs, rt, out_ready,
    input  in_ready, out_valid, result, div_by_zero, busy
  );

  modport slave (
    input  in_valid, mode, rs, rt, out_ready,
    output in_ready, out_valid, result, div_by_zero, busy
  );
endinterface

// File: rtl/muldiv_seq_cop.sv
// Iterative shift-add multiplier / restoring divider; DATA_W+2 edges incl. accept (divide-by-zero: 1).
// Result held in DONE until out_ready; no new request accepted until the result is taken.
module muldiv_seq_cop #(
  parameter int DATA_W    = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  muldiv_seq_cop_if.slave  bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                op_div, neg_q, neg_r, dbz_q;
  logic [DATA_W-1:0]   opnd;
  logic [2*DATA_W-1:0] acc, acc_step, res_q;

  logic                accept, div_zero, is_signed, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag, quo_f, rem_f;
  logic [DATA_W:0]     mul_sum, div_part, div_diff;

  assign accept    = bus.in_valid && (state == IDLE);
  assign div_zero  = bus.mode[1] && (bus.rt == '0);
  assign is_signed = SIGNED_EN && bus.mode[0];
  assign a_neg     = is_signed && bus.rs[DATA_W-1];
  assign b_neg     = is_signed && bus.rt[DATA_W-1];
  assign a_mag     = a_neg ? -bus.rs : bus.rs;
  assign b_mag     = b_neg ? -bus.rt : bus.rt;

  // acc = {high half, low half}: MUL keeps the multiplier in the low half and
  // shifts right; DIV keeps the dividend there and shifts quotient bits in from the right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_part = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff = div_part - {1'b0, opnd};
    if (!op_div)
      acc_step = {mul_sum, acc[DATA_W-1:1]};
    else if (div_diff[DATA_W])
      acc_step = {div_part[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    else
      acc_step = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    quo_f = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem_f = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
      CALC: if (cnt == CW'(DATA_W-1)) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            op_div <= bus.mode[1];
            cnt    <= '0;
            if (div_zero) begin
              res_q <= {{DATA_W{1'b1}}, bus.rs};
              dbz_q <= 1'b1;
            end else begin
              dbz_q <= 1'b0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              opnd  <= bus.mode[1] ? b_mag : a_mag;
              acc   <= {{DATA_W{1'b0}}, (bus.mode[1] ? a_mag : b_mag)};
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          if (cnt != CW'(DATA_W-1)) cnt <= cnt + CW'(1);
        end
        // Remainder follows the dividend's sign; quotient truncates toward zero.
        SIGN: res_q <= op_div ? {quo_f, rem_f} : (neg_q ? -acc : acc);
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.result      = res_q;
  assign bus.div_by_zero = dbz_q;
endmodule
